// File: rtl/pu_queue_fifo_ctrl.sv
// Queue controller in front of a synchronous single-port-per-direction payload RAM.
// A 2-entry output buffer hides the one-cycle RAM read latency so dequeue can sustain one per cycle.
module pu_queue_fifo_ctrl #(
    parameter int DEPTH_NBITS = 4,
    parameter int DEPTH       = 1 << DEPTH_NBITS,
    parameter int PAYLOAD_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [PAYLOAD_W-1:0]   enq_data,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [PAYLOAD_W-1:0]   deq_data,
    output logic                   ram_wr,
    output logic [DEPTH_NBITS-1:0] ram_waddr,
    output logic [DEPTH_NBITS-1:0] ram_raddr,
    output logic [PAYLOAD_W-1:0]   ram_din,
    input  logic [PAYLOAD_W-1:0]   ram_dout,
    output logic [DEPTH_NBITS:0]   count
);

    localparam int CW = DEPTH_NBITS + 1;
    localparam logic [DEPTH_NBITS-1:0] LAST_PTR = DEPTH_NBITS'(DEPTH - 1);
    localparam logic [CW-1:0]          DEPTH_C  = CW'(DEPTH);

    logic [DEPTH_NBITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_NBITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CW-1:0]          ram_cnt_q, ram_cnt_d;
    logic                   inflight_q;
    logic                   enq_ready_q, enq_ready_d;
    logic [1:0]             buf_cnt_q, buf_cnt_d;
    logic [PAYLOAD_W-1:0]   buf0_q, buf0_d;
    logic [PAYLOAD_W-1:0]   buf1_q, buf1_d;

    logic       enq_fire;
    logic       deq_fire;
    logic       rd_issue;
    logic [2:0] occ;

    assign enq_fire = enq_valid && enq_ready_q && !flush;
    assign deq_fire = deq_valid && deq_ready && !flush;

    // ram_cnt_q only counts entries written on an earlier edge, so a read never
    // targets the entry being written this cycle.
    assign occ      = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(deq_fire);
    assign rd_issue = (ram_cnt_q != '0) && (occ < 3'd2);

    assign enq_ready = enq_ready_q;
    assign deq_valid = (buf_cnt_q != 2'd0);
    assign deq_data  = buf0_q;
    assign ram_wr    = enq_fire;
    assign ram_waddr = wr_ptr_q;
    assign ram_din   = enq_data;
    assign ram_raddr = rd_ptr_q;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (enq_fire) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + DEPTH_NBITS'(1);
        end
        if (rd_issue) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + DEPTH_NBITS'(1);
        end
        count_d     = count_q + CW'(enq_fire) - CW'(deq_fire);
        ram_cnt_d   = ram_cnt_q + CW'(enq_fire) - CW'(rd_issue);
        enq_ready_d = (count_d < DEPTH_C);
    end

    // Output buffer: pop the head first, then land the returning read behind
    // whatever remains so order is preserved.
    always_comb begin
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        buf_cnt_d = buf_cnt_q;
        if (deq_fire) begin
            buf0_d    = buf1_q;
            buf_cnt_d = buf_cnt_q - 2'd1;
        end
        if (inflight_q) begin
            if (buf_cnt_d == 2'd0) begin
                buf0_d = ram_dout;
            end else begin
                buf1_d = ram_dout;
            end
            buf_cnt_d = buf_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ram_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            enq_ready_q <= 1'b0;
            buf_cnt_q   <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
        end else if (flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ram_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            enq_ready_q <= (DEPTH_C != '0);
            buf_cnt_q   <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ram_cnt_q   <= ram_cnt_d;
            inflight_q  <= rd_issue;
            enq_ready_q <= enq_ready_d;
            buf_cnt_q   <= buf_cnt_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
        end
    end

endmodule
